// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared FSM encoding, counter widths and default timing for the lock reset sequencer.
package clk_rst_pkg;
    typedef enum logic [2:0] {WAIT_LOCK, STABLE, RELEASE, RUN, FAULT} state_t;
    localparam int LOST_CNT_W           = 8;
    localparam int DEF_STAGE_NUM        = 3;
    localparam int DEF_SYNC_STAGES      = 2;
    localparam int DEF_LOCK_STABLE_CYC  = 1000;
    localparam int DEF_STAGE_GAP_CYC    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 100000;
    localparam int DEF_GLITCH_CYC       = 4;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: N-flop synchronizer for an asynchronous flag, async active-high reset to 0.
module sync_bit #(
    parameter int N = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [N-1:0] r_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_q <= '0;
        else r_q <= {r_q[N-2:0], i_d};
    end
    assign o_q = r_q[N-1];
endmodule

// File: rtl/clk_lock_rst_seq.sv
// clk_lock_rst_seq: qualifies the clock-wizard lock, then releases staged resets in order.
// Define LOCK_GLITCH_FILTER_EN to ignore lock drops shorter than GLITCH_CYC once release has begun.
module clk_lock_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int STAGE_NUM        = DEF_STAGE_NUM,
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int STAGE_GAP_CYC    = DEF_STAGE_GAP_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC
`ifdef LOCK_GLITCH_FILTER_EN
    ,
    parameter int GLITCH_CYC       = DEF_GLITCH_CYC
`endif
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  locked,
    output logic [STAGE_NUM-1:0]  rst_stage,
    output logic                  all_ready,
    output logic                  fault,
    output logic [LOST_CNT_W-1:0] lock_lost_cnt
);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYC) + 1;
    localparam int SW = $clog2(LOCK_STABLE_CYC) + 1;
    localparam int GW = $clog2(STAGE_GAP_CYC) + 1;

    state_t                r_state, w_state;
    logic [TW-1:0]         r_tmo, w_tmo;
    logic [SW-1:0]         r_stab, w_stab;
    logic [GW-1:0]         r_gap, w_gap;
    logic [STAGE_NUM-1:0]  r_rst, w_rst, w_shift;
    logic                  r_ready, w_ready, r_fault, w_fault;
    logic [LOST_CNT_W-1:0] r_lost, w_lost;
    logic                  w_lock_s, w_act, w_loss, w_hold;

    sync_bit #(.N(SYNC_STAGES)) u_sync (
        .i_clk(sys_clk),
        .i_rst(sys_rst),
        .i_d  (locked),
        .o_q  (w_lock_s)
    );

    assign w_act   = (r_state == RELEASE) || (r_state == RUN);
    // Stages clear LSB-first, so releasing the next stage is a left shift of the mask
    assign w_shift = r_rst << 1;

`ifdef LOCK_GLITCH_FILTER_EN
    localparam int LW = $clog2(GLITCH_CYC) + 1;
    logic [LW-1:0] r_low, w_low;
    assign w_low  = (w_lock_s || !w_act) ? '0 : r_low + 1'b1;
    assign w_loss = !w_lock_s && (r_low == LW'(GLITCH_CYC - 1));
    assign w_hold = !w_lock_s;
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_low <= '0;
        else r_low <= w_low;
    end
`else
    assign w_loss = !w_lock_s;
    assign w_hold = 1'b0;
`endif

    always_comb begin
        w_state = r_state;
        w_tmo   = r_tmo;
        w_stab  = r_stab;
        w_gap   = r_gap;
        w_rst   = r_rst;
        w_ready = r_ready;
        w_fault = r_fault;
        w_lost  = r_lost;
        if (w_act && w_loss) begin
            w_state = WAIT_LOCK;
            w_tmo   = '0;
            w_rst   = '1;
            w_ready = 1'b0;
            w_lost  = (&r_lost) ? r_lost : r_lost + 1'b1;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    w_tmo = r_tmo + 1'b1;
                    if (w_lock_s) begin
                        w_state = STABLE;
                        w_stab  = '0;
                    end else if (r_tmo == TW'(LOCK_TIMEOUT_CYC - 1)) begin
                        w_state = FAULT;
                        w_fault = 1'b1;
                    end
                end
                STABLE: begin
                    w_stab = r_stab + 1'b1;
                    if (!w_lock_s) begin
                        w_state = WAIT_LOCK;
                        w_tmo   = '0;
                    end else if (r_stab == SW'(LOCK_STABLE_CYC - 1)) begin
                        w_rst   = w_shift;
                        w_gap   = '0;
                        w_ready = ~|w_shift;
                        w_state = ~|w_shift ? RUN : RELEASE;
                    end
                end
                RELEASE: begin
                    if (!w_hold) begin
                        w_gap = (r_gap == GW'(STAGE_GAP_CYC - 1)) ? '0 : r_gap + 1'b1;
                        if (r_gap == GW'(STAGE_GAP_CYC - 1)) begin
                            w_rst   = w_shift;
                            w_ready = ~|w_shift;
                            w_state = ~|w_shift ? RUN : RELEASE;
                        end
                    end
                end
                FAULT: begin
                    if (w_lock_s) begin
                        w_state = STABLE;
                        w_stab  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= WAIT_LOCK;
            r_tmo   <= '0;
            r_stab  <= '0;
            r_gap   <= '0;
            r_rst   <= '1;
            r_ready <= 1'b0;
            r_fault <= 1'b0;
            r_lost  <= '0;
        end else begin
            r_state <= w_state;
            r_tmo   <= w_tmo;
            r_stab  <= w_stab;
            r_gap   <= w_gap;
            r_rst   <= w_rst;
            r_ready <= w_ready;
            r_fault <= w_fault;
            r_lost  <= w_lost;
        end
    end

    assign rst_stage     = r_rst;
    assign all_ready     = r_ready;
    assign fault         = r_fault;
    assign lock_lost_cnt = r_lost;
endmodule

// File: tb/tb_clk_lock_rst_seq.sv
// tb_clk_lock_rst_seq: directed table, hand sequences and random lock traffic against an event-level model.
module tb_clk_lock_rst_seq;
    localparam int STAGES = 3;
    localparam int SYNC   = 2;
    localparam int STAB   = 8;
    localparam int GAP    = 4;
    localparam int TMO    = 50;
`ifdef LOCK_GLITCH_FILTER_EN
    localparam int G = 4;
`else
    localparam int G = 1;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        locked;
    logic [2:0]  rst_stage;
    logic        all_ready;
    logic        fault;
    logic [7:0]  lock_lost_cnt;

    clk_lock_rst_seq #(
        .STAGE_NUM       (STAGES),
        .SYNC_STAGES     (SYNC),
        .LOCK_STABLE_CYC (STAB),
        .STAGE_GAP_CYC   (GAP),
        .LOCK_TIMEOUT_CYC(TMO)
`ifdef LOCK_GLITCH_FILTER_EN
        , .GLITCH_CYC    (G)
`endif
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .locked       (locked),
        .rst_stage    (rst_stage),
        .all_ready    (all_ready),
        .fault        (fault),
        .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: an attempt starts when synchronized lock is seen high while idle;
    // stages are released by counting high edges after that start.
    logic q[$];
    int   m_n, m_w, m_hi, m_low, m_mode, m_lost;
    logic m_fault;

    task automatic model_reset();
        q.delete();
        m_n = 0; m_w = 0; m_hi = 0; m_low = 0; m_mode = 0; m_lost = 0; m_fault = 1'b0;
    endtask

    function automatic int m_rel();
        int r;
        r = (m_mode == 2 && m_hi >= STAB) ? 1 + (m_hi - STAB) / GAP : 0;
        return (r > STAGES) ? STAGES : r;
    endfunction

    task automatic model_step(input logic c);
        logic ls;
        int   rel;
        ls = (q.size() >= SYNC) ? q[q.size() - SYNC] : 1'b0;
        q.push_back(c);
        if (q.size() > SYNC) void'(q.pop_front());
        rel = m_rel();
        m_n++;
        if (m_mode != 2) begin
            if (ls) begin
                m_mode = 2; m_hi = 0; m_low = 0;
            end else if (m_mode == 0 && m_n - m_w == TMO) begin
                m_mode = 1; m_fault = 1'b1;
            end
        end else if (ls) begin
            m_hi++; m_low = 0;
        end else if (rel == 0) begin
            m_mode = 0; m_w = m_n;
        end else begin
            m_low++;
            if (m_low == G) begin
                m_lost = (m_lost < 255) ? m_lost + 1 : 255;
                m_mode = 0; m_w = m_n;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic [2:0] r, input logic rd, input logic f, input int l);
        chk({nm, ".rst_stage"}, 32'(rst_stage), 32'(r));
        chk({nm, ".all_ready"}, 32'(all_ready), 32'(rd));
        chk({nm, ".fault"}, 32'(fault), 32'(f));
        chk({nm, ".lost_cnt"}, 32'(lock_lost_cnt), 32'(l));
    endtask

    task automatic cycle(input logic l);
        locked = l;
        @(posedge sys_clk);
        model_step(l);
        @(negedge sys_clk);
    endtask

    task automatic cycles(input logic l, input int n);
        for (int i = 0; i < n; i++) cycle(l);
    endtask

    // Called at a falling edge; reset is raised between clock edges.
    task automatic do_reset(input bit chk_now);
        #2 sys_rst = 1'b1;
        #1 if (chk_now) chk_all("async_rst", 3'b111, 1'b0, 1'b0, 0);
        @(negedge sys_clk);
        locked = 1'b0;
        sys_rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       lk;
        int         n;
        logic [2:0] r;
        logic       rd;
        int         lost;
    } vec_t;
    vec_t tbl[13];

    initial begin
        logic v;
        int   len;
        tbl[0]  = '{1'b1, 10,    3'b111, 1'b0, 0};
        tbl[1]  = '{1'b1, 1,     3'b110, 1'b0, 0};
        tbl[2]  = '{1'b1, 3,     3'b110, 1'b0, 0};
        tbl[3]  = '{1'b1, 1,     3'b100, 1'b0, 0};
        tbl[4]  = '{1'b1, 3,     3'b100, 1'b0, 0};
        tbl[5]  = '{1'b1, 1,     3'b000, 1'b1, 0};
        tbl[6]  = '{1'b1, 5,     3'b000, 1'b1, 0};
        tbl[7]  = '{1'b0, G + 1, 3'b000, 1'b1, 0};
        tbl[8]  = '{1'b0, 1,     3'b111, 1'b0, 1};
        tbl[9]  = '{1'b1, 10,    3'b111, 1'b0, 1};
        tbl[10] = '{1'b1, 1,     3'b110, 1'b0, 1};
        tbl[11] = '{1'b1, 7,     3'b100, 1'b0, 1};
        tbl[12] = '{1'b1, 1,     3'b000, 1'b1, 1};

        sys_rst = 1'b1;
        locked  = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk_all("reset", 3'b111, 1'b0, 1'b0, 0);
        sys_rst = 1'b0;
        model_reset();

        // Start-up, loss in RUN and re-lock
        for (int i = 0; i < 13; i++) begin
            cycles(tbl[i].lk, tbl[i].n);
            chk_all($sformatf("tbl%0d", i), tbl[i].r, tbl[i].rd, 1'b0, tbl[i].lost);
        end

`ifdef LOCK_GLITCH_FILTER_EN
        cycles(1'b0, 3);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1);
            chk_all("glitch3", 3'b000, 1'b1, 1'b0, 1);
        end
        cycles(1'b0, 4);
        cycle(1'b1);
        chk_all("glitch4_pre", 3'b000, 1'b1, 1'b0, 1);
        cycle(1'b1);
        chk_all("glitch4", 3'b111, 1'b0, 1'b0, 2);
`endif

        // Reset while stages are being released
        cycles(1'b0, 8);
        cycles(1'b1, 13);
        chk("mid_release.rst_stage", 32'(rst_stage), 32'h6);
        do_reset(1'b1);

        // Chatter before release is not a loss
        cycles(1'b1, 5);
        cycle(1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1);
            chk_all("chatter", 3'b111, 1'b0, 1'b0, 0);
        end
        cycle(1'b1);
        chk_all("chatter_rel", 3'b110, 1'b0, 1'b0, 0);

        // Timeout, then late lock
        do_reset(1'b0);
        cycles(1'b0, 49);
        chk_all("tmo_pre", 3'b111, 1'b0, 1'b0, 0);
        cycle(1'b0);
        chk_all("tmo", 3'b111, 1'b0, 1'b1, 0);
        cycles(1'b1, 18);
        chk_all("tmo_late_pre", 3'b100, 1'b0, 1'b1, 0);
        cycle(1'b1);
        chk_all("tmo_late_lock", 3'b000, 1'b1, 1'b1, 0);

        // Lock seen on the timeout cycle wins over fault
        do_reset(1'b0);
        cycles(1'b0, 47);
        cycles(1'b1, 3);
        chk_all("tmo_race", 3'b111, 1'b0, 1'b0, 0);
        cycles(1'b1, 8);
        chk_all("tmo_race_rel", 3'b110, 1'b0, 1'b0, 0);

        // Random lock traffic against the model
        do_reset(1'b0);
        for (int i = 0; i < 160; i++) begin
            v = (i % 2 == 0);
            if (v) len = int'($urandom_range(1, 45));
            else if ($urandom_range(0, 7) == 0) len = int'($urandom_range(45, 70));
            else len = int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) begin
                cycle(v);
                chk_all("rand", 3'b111 << m_rel(), m_rel() == STAGES, m_fault, m_lost);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
